// File: rtl/ps2_pkg.sv
// Shared scan-code constants, decoder state encoding and the
// scan-code-set-2 to ASCII translation used by ps2_key_decoder.
package ps2_pkg;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_SPACE  = 8'h29;

    localparam int         N_IGNORED = 6;
    localparam logic [7:0] SC_IGNORED [N_IGNORED] = '{
        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GOT_E0,
        ST_GOT_F0,
        ST_GOT_E0F0
    } dec_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic [7:0] ascii;
    } key_evt_t;

    function automatic logic is_ignored(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_IGNORED; i++)
            if (code == SC_IGNORED[i])
                hit = 1'b1;
        return hit;
    endfunction

    function automatic logic [7:0] scan_to_ascii(
        input logic [7:0] code,
        input logic       shift,
        input logic       upper
    );
        logic [7:0] lc;
        logic [7:0] dg;
        logic [7:0] sy;
        lc = 8'h00;
        dg = 8'h00;
        sy = 8'h00;
        case (code)
            8'h1C: lc = "a";
            8'h32: lc = "b";
            8'h21: lc = "c";
            8'h23: lc = "d";
            8'h24: lc = "e";
            8'h2B: lc = "f";
            8'h34: lc = "g";
            8'h33: lc = "h";
            8'h43: lc = "i";
            8'h3B: lc = "j";
            8'h42: lc = "k";
            8'h4B: lc = "l";
            8'h3A: lc = "m";
            8'h31: lc = "n";
            8'h44: lc = "o";
            8'h4D: lc = "p";
            8'h15: lc = "q";
            8'h2D: lc = "r";
            8'h1B: lc = "s";
            8'h2C: lc = "t";
            8'h3C: lc = "u";
            8'h2A: lc = "v";
            8'h1D: lc = "w";
            8'h22: lc = "x";
            8'h35: lc = "y";
            8'h1A: lc = "z";
            8'h16: begin dg = "1"; sy = "!"; end
            8'h1E: begin dg = "2"; sy = "@"; end
            8'h26: begin dg = "3"; sy = "#"; end
            8'h25: begin dg = "4"; sy = "$"; end
            8'h2E: begin dg = "5"; sy = "%"; end
            8'h36: begin dg = "6"; sy = "^"; end
            8'h3D: begin dg = "7"; sy = "&"; end
            8'h3E: begin dg = "8"; sy = "*"; end
            8'h46: begin dg = "9"; sy = "("; end
            8'h45: begin dg = "0"; sy = ")"; end
            default: ;
        endcase
        if (lc != 8'h00)
            return upper ? lc - 8'h20 : lc;
        if (dg != 8'h00)
            return shift ? sy : dg;
        case (code)
            SC_SPACE: return 8'h20;
            SC_ENTER: return 8'h0D;
            SC_BKSP:  return 8'h08;
            default:  return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the receiver byte strobe with a
// single-cycle pulse on its synchronized rising edge.
module ps2_sync_edge (
    input  logic CLK,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// Scan-code set 2 byte stream to key events: prefix FSM,
// Shift / Caps Lock tracking and registered event outputs.
module ps2_key_decoder
    import ps2_pkg::*;
(
    input  logic       CLK,
    input  logic       reset,
    input  logic       newChar,
    input  logic [7:0] char,
    output logic       keyValid,
    output logic [7:0] keyCode,
    output logic       keyExtended,
    output logic       keyReleased,
    output logic [7:0] ascii,
    output logic       shiftDown,
    output logic       capsLock
);

    logic       rise;
    logic       drop;
    logic       is_e0;
    logic       is_f0;
    dec_state_t state_q;
    dec_state_t state_d;
    logic       emit;
    logic       emit_ext;
    logic       emit_rel;
    logic       mod_ev;
    key_evt_t   evt_d;
    key_evt_t   evt_q;
    logic       valid_q;
    logic       lshift_q;
    logic       rshift_q;
    logic       caps_held_q;
    logic       caps_q;

    ps2_sync_edge u_sync (
        .CLK   (CLK),
        .reset (reset),
        .in    (newChar),
        .rise  (rise)
    );

    assign drop  = is_ignored(char);
    assign is_e0 = (char == SC_E0);
    assign is_f0 = (char == SC_F0);

    always_ff @(posedge CLK) begin
        if (!reset)
            state_q <= ST_IDLE;
        else if (rise)
            state_q <= state_d;
    end

    // Prefixes accumulate: E0 and F0 in either order reach GOT_E0F0.
    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            drop:  state_d = ST_IDLE;
            is_e0: state_d = (state_q inside {ST_GOT_F0, ST_GOT_E0F0})
                             ? ST_GOT_E0F0 : ST_GOT_E0;
            is_f0: state_d = (state_q inside {ST_GOT_E0, ST_GOT_E0F0})
                             ? ST_GOT_E0F0 : ST_GOT_F0;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_rel = 1'b0;
        if (!drop && !is_e0 && !is_f0) begin
            emit     = 1'b1;
            emit_ext = state_q inside {ST_GOT_E0, ST_GOT_E0F0};
            emit_rel = state_q inside {ST_GOT_F0, ST_GOT_E0F0};
        end
        evt_d.code  = char;
        evt_d.ext   = emit_ext;
        evt_d.rel   = emit_rel;
        evt_d.ascii = (emit_ext || emit_rel) ? 8'h00
                    : scan_to_ascii(char, shiftDown, shiftDown ^ caps_q);
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            valid_q <= 1'b0;
            evt_q   <= '0;
        end else begin
            valid_q <= rise & emit;
            if (rise && emit)
                evt_q <= evt_d;
        end
    end

    assign mod_ev = rise & emit & ~emit_ext;

    // Caps-held blocks typematic repeats from re-toggling.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_held_q <= 1'b0;
            caps_q      <= 1'b0;
        end else if (mod_ev) begin
            if (char == SC_LSHIFT)
                lshift_q <= ~emit_rel;
            if (char == SC_RSHIFT)
                rshift_q <= ~emit_rel;
            if (char == SC_CAPS) begin
                if (emit_rel) begin
                    caps_held_q <= 1'b0;
                end else begin
                    if (!caps_held_q)
                        caps_q <= ~caps_q;
                    caps_held_q <= 1'b1;
                end
            end
        end
    end

    assign keyValid    = valid_q;
    assign keyCode     = evt_q.code;
    assign keyExtended = evt_q.ext;
    assign keyReleased = evt_q.rel;
    assign ascii       = evt_q.ascii;
    assign shiftDown   = lshift_q | rshift_q;
    assign capsLock    = caps_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed and random byte streams against a flag-based model of
// prefix resolution, modifiers and US-layout translation.
module tb_ps2_key_decoder;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       newChar = 1'b0;
    logic [7:0] char = 8'h00;
    logic       keyValid;
    logic [7:0] keyCode;
    logic       keyExtended;
    logic       keyReleased;
    logic [7:0] ascii;
    logic       shiftDown;
    logic       capsLock;

    int n_chk = 0;
    int n_pass = 0;

    ps2_key_decoder dut (
        .CLK         (CLK),
        .reset       (reset),
        .newChar     (newChar),
        .char        (char),
        .keyValid    (keyValid),
        .keyCode     (keyCode),
        .keyExtended (keyExtended),
        .keyReleased (keyReleased),
        .ascii       (ascii),
        .shiftDown   (shiftDown),
        .capsLock    (capsLock)
    );

    always #5 CLK = ~CLK;

    string     letters = "abcdefghijklmnopqrstuvwxyz";
    logic [7:0] letter_sc [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };
    string     digits = "1234567890";
    string     syms   = "!@#$%^&*()";
    logic [7:0] digit_sc [10] = '{
        8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45
    };

    // model state
    bit         pend_e0, pend_f0;
    bit         m_lsh, m_rsh, m_caps, m_caps_held;
    bit         m_emit;
    logic [7:0] m_code, m_ascii;
    bit         m_ext, m_rel;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        pend_e0 = 0; pend_f0 = 0;
        m_lsh = 0; m_rsh = 0; m_caps = 0; m_caps_held = 0;
        m_code = 0; m_ascii = 0; m_ext = 0; m_rel = 0; m_emit = 0;
    endtask

    function automatic logic [7:0] translate(input logic [7:0] b,
                                             input bit sh, input bit cl);
        for (int k = 0; k < 26; k++)
            if (letter_sc[k] == b)
                return (sh ^ cl) ? letters[k] - 8'd32 : letters[k];
        for (int k = 0; k < 10; k++)
            if (digit_sc[k] == b)
                return sh ? syms[k] : digits[k];
        if (b == 8'h29) return 8'h20;
        if (b == 8'h5A) return 8'h0D;
        if (b == 8'h66) return 8'h08;
        return 8'h00;
    endfunction

    task automatic model_step(input logic [7:0] b);
        m_emit = 0;
        if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
            pend_e0 = 0; pend_f0 = 0;
            return;
        end
        if (b == 8'hE0) begin pend_e0 = 1; return; end
        if (b == 8'hF0) begin pend_f0 = 1; return; end
        m_emit = 1;
        m_code = b;
        m_ext  = pend_e0;
        m_rel  = pend_f0;
        m_ascii = (m_ext || m_rel) ? 8'h00
                : translate(b, m_lsh || m_rsh, m_caps);
        if (!m_ext) begin
            if (b == 8'h12) m_lsh = !m_rel;
            if (b == 8'h59) m_rsh = !m_rel;
            if (b == 8'h58) begin
                if (m_rel)
                    m_caps_held = 0;
                else begin
                    if (!m_caps_held) m_caps = !m_caps;
                    m_caps_held = 1;
                end
            end
        end
        pend_e0 = 0; pend_f0 = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_code"}, keyCode, m_code);
        chk({tag, "_ext"}, keyExtended, m_ext);
        chk({tag, "_rel"}, keyReleased, m_rel);
        chk({tag, "_ascii"}, ascii, m_ascii);
        chk({tag, "_shift"}, shiftDown, m_lsh || m_rsh);
        chk({tag, "_caps"}, capsLock, m_caps);
    endtask

    // Edge index 0 is E, the first edge that sees newChar high.
    task automatic send_byte(input logic [7:0] b, input int hold);
        int pulses;
        model_step(b);
        pulses = 0;
        @(negedge CLK);
        char = b;
        newChar = 1'b1;
        for (int i = 0; i < hold + 6; i++) begin
            @(posedge CLK);
            #1;
            if (keyValid) pulses++;
            if (i == 2) chk("kv_at_e2", keyValid, m_emit);
            if (i == hold - 1) begin
                @(negedge CLK);
                newChar = 1'b0;
            end
        end
        chk("pulses", pulses, m_emit);
        check_outputs("byte");
    endtask

    task automatic pulse_reset(input int cycles);
        @(negedge CLK);
        reset = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLK);
            #1;
            chk("rst_valid", keyValid, 0);
            chk("rst_code", keyCode, 0);
            chk("rst_ext", keyExtended, 0);
            chk("rst_rel", keyReleased, 0);
            chk("rst_ascii", ascii, 0);
            chk("rst_shift", shiftDown, 0);
            chk("rst_caps", capsLock, 0);
        end
        @(negedge CLK);
        reset = 1'b1;
        model_reset();
    endtask

    logic [7:0] mods [3] = '{8'h12, 8'h59, 8'h58};
    logic [7:0] misc [6] = '{8'h29, 8'h5A, 8'h66, 8'hAA, 8'h00, 8'hFA};

    initial begin
        model_reset();
        pulse_reset(3);

        send_byte(8'h1C, 10);
        chk("tp1_a", ascii, 8'h61);
        send_byte(8'hF0, 10);
        send_byte(8'h1C, 10);
        chk("tp1_brk", keyReleased, 1);

        send_byte(8'h12, 9);
        chk("tp2_sh_on", shiftDown, 1);
        send_byte(8'h1C, 9);
        chk("tp2_A", ascii, 8'h41);
        send_byte(8'hF0, 9);
        send_byte(8'h12, 9);
        chk("tp2_sh_off", shiftDown, 0);
        send_byte(8'h1C, 9);
        chk("tp2_a", ascii, 8'h61);

        send_byte(8'h58, 8);
        chk("tp3_caps1", capsLock, 1);
        send_byte(8'h58, 8);
        chk("tp3_rep", capsLock, 1);
        send_byte(8'hF0, 8);
        send_byte(8'h58, 8);
        send_byte(8'h1C, 8);
        chk("tp3_A", ascii, 8'h41);
        send_byte(8'h58, 8);
        send_byte(8'hF0, 8);
        send_byte(8'h58, 8);
        chk("tp3_caps0", capsLock, 0);

        send_byte(8'hE0, 12);
        send_byte(8'h75, 12);
        chk("tp4_ext", keyExtended, 1);
        send_byte(8'hE0, 12);
        send_byte(8'hF0, 12);
        send_byte(8'h75, 12);
        chk("tp4_rel", keyReleased, 1);

        send_byte(8'hAA, 10);
        send_byte(8'hFA, 10);
        send_byte(8'hE0, 10);
        pulse_reset(1);
        send_byte(8'h16, 10);
        chk("tp5_ext", keyExtended, 0);
        chk("tp5_one", ascii, 8'h31);

        send_byte(8'h29, 20);
        chk("tp6_space", ascii, 8'h20);

        for (int n = 0; n < 200; n++) begin
            logic [7:0] b;
            case ($urandom_range(0, 9))
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4:       b = mods[$urandom_range(0, 2)];
                5, 6:    b = letter_sc[$urandom_range(0, 25)];
                7:       b = digit_sc[$urandom_range(0, 9)];
                8:       b = misc[$urandom_range(0, 5)];
                default: b = 8'($urandom);
            endcase
            send_byte(b, $urandom_range(8, 20));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Consumes the byte stream from the PS/2 receiver (`newChar`/`char`) and turns raw scan-code set 2 bytes into key events on the system clock. Resolves `E0` (extended) and `F0` (break) prefixes, tracks Shift and Caps Lock, and translates common make codes to ASCII. It sits directly downstream of the receiver and feeds the display/text logic.

## Interface
- No parameters.
- `CLK` in 1: system clock; must be at least 8× the PS/2 clock rate.
- `reset` in 1: synchronous, active-low.
- `newChar` in 1: receiver byte strobe; asynchronous to `CLK`, high for about one PS/2 clock period.
- `char` in 8: receiver byte; stable while `newChar` is high.
- `keyValid` out 1: one-`CLK` pulse per completed key event.
- `keyCode` out 8: scan code of the event, without prefixes.
- `keyExtended` out 1: event was `E0`-prefixed.
- `keyReleased` out 1: event was a break (`F0`).
- `ascii` out 8: translated character; `8'h00` if unmapped, extended or released.
- `shiftDown` out 1: left or right Shift currently held.
- `capsLock` out 1: Caps Lock toggle state.

## Operation
- **Byte acceptance**
  - `newChar` passes through a 2-flop synchronizer.
  - A rising edge of the synchronized signal accepts one byte: `char` is registered on that `CLK` edge.
- **Ignored bytes**
  - `00`, `AA`, `EE`, `FA`, `FE` and `FF` are dropped.
  - The FSM returns to IDLE.
  - No event is produced.
- **FSM states:** IDLE, GOT_E0, GOT_F0, GOT_E0F0.
  - IDLE: `E0` goes to GOT_E0. `F0` goes to GOT_F0. Any other byte emits a make event (ext=0) and stays in IDLE.
  - GOT_E0: `F0` goes to GOT_E0F0. `E0` stays in GOT_E0. Any other byte emits a make event (ext=1) and goes to IDLE.
  - GOT_F0: `F0` stays in GOT_F0. `E0` goes to GOT_E0F0. Any other byte emits a break event (ext=0) and goes to IDLE.
  - GOT_E0F0: `E0`/`F0` stay in GOT_E0F0. Any other byte emits a break event (ext=1) and goes to IDLE.
- **Event emission**
  - Registers `keyCode`, `keyExtended`, `keyReleased` and `ascii`, and pulses `keyValid`.
  - Event outputs hold their values until the next event.
- **Shift**
  - Non-extended make of `12` or `59` sets the corresponding held flag; the matching break clears it.
  - `shiftDown` = OR of the two flags.
- **Caps Lock**
  - Non-extended make of `58` toggles `capsLock` only when the caps-held flag is 0, then sets caps-held.
  - Break of `58` clears caps-held.
  - Typematic repeats therefore do not re-toggle.
- **Modifier timing:** modifier updates take effect on the same edge as their event. Translation of the event uses the modifier state from before that edge.
- **ASCII translation** (non-extended makes only)
  - Letters: lowercase, or uppercase when `shiftDown ^ capsLock`.
  - Digits: the digit; with Shift, the US symbols `!@#$%^&*()`.
  - Space `29` → `20`, Enter `5A` → `0D`, Backspace `66` → `08`.
  - Everything else → `00`.

## Timing
- **Latency:** let edge E be the first `CLK` edge at which sync stage 1 samples `newChar`=1. Then:
  - the byte is accepted at E+2;
  - `keyValid` is high for exactly the cycle after E+2 (registered outputs valid from E+3).
- **One event per strobe:** one byte per `newChar` high period, regardless of how long it stays high.
- **Reset**
  - Reset active at any edge: all outputs become 0, the FSM goes to IDLE, and the synchronizer, shift-held and caps-held flags clear.
  - Reset has priority over an acceptance on the same edge.
  - Reset mid-prefix discards the prefix.
- **Prefix-only byte:** a byte that only advances the FSM produces no `keyValid`.

## Structure
- Package `ps2_pkg`:
  - scan-code constants (`SC_E0`, `SC_F0`, `SC_LSHIFT`, `SC_RSHIFT`, `SC_CAPS`, `SC_ENTER`, `SC_BKSP`, `SC_SPACE`, ignored-code list);
  - FSM state encoding;
  - function `scan_to_ascii(code, shift, upper)`.
- Sub-module `ps2_sync_edge`: 2-flop synchronizer plus rising-edge pulse (inputs `CLK`, `reset`, `in`; output `rise`).
- The decoder FSM, modifier tracking and output registers live in `ps2_key_decoder`.

## Test plan
- Bytes `1C`, then `F0 1C` → event 1: `keyValid`, `keyCode`=`1C`, `ascii`=`61`, released=0. Event 2: `keyCode`=`1C`, released=1, `ascii`=`00`. Exactly two pulses.
- `12` (LShift), `1C`, `F0 12`, `1C` → `shiftDown` is 1 between the first two and 0 after. The two `1C` events give `ascii`=`41`, then `61`.
- `58`, `58`, `F0 58`, `1C` → `capsLock`=1 after the first `58` and stays 1 after the repeat. The `1C` event gives `ascii`=`41`. Then `58`, `F0 58` brings `capsLock` back to 0.
- `E0 75`, then `E0 F0 75` → two events: ext=1, `keyCode`=`75`, released=0/1, `ascii`=`00`.
- `AA`, `FA`, `E0` then reset low for one cycle, then `16` → no event for `AA`/`FA`/`E0`. All outputs are 0 during reset. The final event has ext=0, `keyCode`=`16`, `ascii`=`31`.
- Hold `newChar` high for 20 `CLK` cycles with `char`=`29` → exactly one `keyValid`, `ascii`=`20`. It occurs in the cycle after E+2, where E is the first `CLK` edge at which sync stage 1 samples `newChar`=1.
